// File: rtl/window_packer.sv
// Packs DATA_W-bit elements into ELEMS-lane vectors; vector valid one edge after its closing beat.
// Backpressure: one closed vector parks in assembly while the output stalls; s_ready drops only then.
module window_packer #(
    parameter int DATA_W    = 8,
    parameter int ELEMS     = 9,
    parameter int EDGE_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [ELEMS*DATA_W-1:0]      m_vector,
    output logic [$clog2(ELEMS+1)-1:0]   m_fill,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int FW = $clog2(ELEMS+1);
    localparam int VW = ELEMS*DATA_W;

    logic          prev_valid;
    logic [FW-1:0] count;
    logic [VW-1:0] asm_vec;
    logic [VW-1:0] closed_vec;
    logic          asm_full;
    logic [FW-1:0] asm_fill;
    logic          asm_last;
    logic          rise;
    logic          accept;
    logic          close_vec;
    logic          out_free;

    assign s_ready   = !rst && !asm_full;
    assign rise      = (EDGE_MODE != 0) ? (s_valid && !prev_valid) : s_valid;
    assign accept    = rise && s_ready;
    assign close_vec = accept && (s_last || (count == FW'(ELEMS-1)));
    assign out_free  = !m_valid || m_ready;

    // Assembly lanes with the current beat merged into lane[count].
    always_comb begin
        closed_vec = asm_vec;
        for (int k = 0; k < ELEMS; k++) begin
            if (count == FW'(k)) begin
                closed_vec[k*DATA_W +: DATA_W] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Edge history runs through reset so a level held across release is not an edge.
        prev_valid <= s_valid;
        if (rst) begin
            count    <= '0;
            asm_vec  <= '0;
            asm_full <= 1'b0;
            asm_fill <= '0;
            asm_last <= 1'b0;
            m_valid  <= 1'b0;
            m_vector <= '0;
            m_fill   <= '0;
            m_last   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (m_valid && m_ready) begin
                if (asm_full) begin
                    m_vector <= asm_vec;
                    m_fill   <= asm_fill;
                    m_last   <= asm_last;
                    asm_full <= 1'b0;
                    asm_vec  <= '0;
                    count    <= '0;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            // accept implies !asm_full, so this never collides with the transfer above.
            if (accept) begin
                if (close_vec) begin
                    if (out_free) begin
                        m_vector <= closed_vec;
                        m_fill   <= count + FW'(1);
                        m_last   <= s_last;
                        m_valid  <= 1'b1;
                        asm_vec  <= '0;
                        count    <= '0;
                    end else begin
                        asm_vec  <= closed_vec;
                        asm_fill <= count + FW'(1);
                        asm_last <= s_last;
                        asm_full <= 1'b1;
                    end
                end else begin
                    asm_vec <= closed_vec;
                    count   <= count + FW'(1);
                end
            end
            if ((EDGE_MODE != 0) && s_valid && !prev_valid && !s_ready && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/window_packer.md
Name: window_packer

Overview:
- Parametrised successor to the 3x3 byte-to-vector bridge in the convolution-1 datapath.
- Packs a stream of DATA_W-bit elements into ELEMS-wide vectors for the MAC array.
- Selectable input mode:
  - Stream mode: full valid/ready handshake.
  - Strobe mode: rising-edge capture, for the slow PS-driven GPIO source.
- Adds output backpressure, a one-vector skid so assembly continues while the output stalls, partial-vector flush on s_last with zero padding, and a dropped-strobe counter.

Parameters:
- DATA_W, 8, element width in bits.
- ELEMS, 9, elements per output vector (kernel size, e.g. 9 or 25); must be >= 2.
- EDGE_MODE, 0, 0 = valid/ready stream capture; 1 = capture on rising edge of s_valid.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset: synchronous, active-high.
- s_data  in  DATA_W  input element.
- s_valid  in  1  element valid (EDGE_MODE=0) or capture strobe (EDGE_MODE=1).
- s_last  in  1  qualifies the accepted beat as the final element of a group; flushes the vector.
- s_ready  out  1  assembly buffer can accept a beat.
- m_vector  out  ELEMS*DATA_W  packed vector; element k at bits [k*DATA_W +: DATA_W], first-received element at lane 0 (LSBs).
- m_fill  out  clog2(ELEMS+1)  number of valid lanes in m_vector (ELEMS, or fewer on flush).
- m_last  out  1  vector was closed by s_last.
- m_valid  out  1  output vector valid; held until accepted.
- m_ready  in  1  downstream accepts vector when m_valid && m_ready.
- drop_cnt  out  CNT_W  strobes lost while s_ready=0 (EDGE_MODE=1 only; stays 0 otherwise).

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, assembly lanes=0, asm_full=0.
  - m_valid=0, m_vector=0, m_fill=0, m_last=0, drop_cnt=0.
  - s_ready is forced 0 while rst=1; beats are ignored.
  - Reset mid-vector discards any partial assembly and any held output without emitting them.
- Strobe tracking:
  - prev_valid <= s_valid on every edge, including during reset.
  - Consequence: a level already high at reset release is not treated as an edge.
- Accept condition:
  - EDGE_MODE=0: s_valid && s_ready.
  - EDGE_MODE=1: s_valid && !prev_valid && s_ready.
  - A level held high captures exactly one element.
- On accept:
  - s_data is written to lane[count].
  - If count==ELEMS-1 or s_last=1, the vector closes; otherwise count++.
- Close:
  - Closed vector = assembly lanes merged with the current beat; unwritten lanes are 0.
  - fill = count+1; last = s_last.
  - If the output slot is free (m_valid=0, or m_valid && m_ready this cycle): load the output registers and set m_valid=1 on the same edge (latency: one edge after the final beat). Assembly then clears and count=0.
  - Otherwise set asm_full=1. s_ready=0 until the output drains. On the handshake edge the assembly transfers to the output, m_valid stays 1, asm_full=0, and count=0.
- s_ready = !rst && !asm_full (combinational).
- Throughput:
  - With m_ready held 1, beats accepted back-to-back with no bubbles; one vector per ELEMS beats.
  - Max one complete vector buffered in assembly plus one in output.
- Output stability: m_vector, m_fill and m_last are stable while m_valid && !m_ready. m_valid falls only on a handshake with no pending asm_full.
- Drop counter:
  - EDGE_MODE=1: a rising edge of s_valid while s_ready=0 increments drop_cnt, saturating at 2^CNT_W-1.
  - Beats arriving when s_ready=0 never corrupt stored data.
- s_last on the ELEMS-th beat: normal full vector with m_fill=ELEMS and m_last=1.
- s_last is ignored when the beat is not accepted.

Test Plan:
- Sequential fill: ELEMS=9, EDGE_MODE=0, m_ready=1; send 0x01..0x09 back-to-back -> one m_valid pulse after the 9th beat; m_vector=0x090807060504030201; m_fill=9; m_last=0; then send 0x0A..0x12 -> second vector with no bubble.
- Flush: send 0xAA,0xBB,0xCC with s_last on 0xCC -> m_vector lanes 0..2 = AA,BB,CC and lanes 3..8 = 0; m_fill=3; m_last=1; next vector starts at lane 0.
- Backpressure: m_ready=0; send 18 beats ->
  - First vector held stable.
  - Second vector assembles; s_ready drops after beat 18; beats 19+ are not accepted.
  - Raise m_ready for 1 cycle -> vector 1 accepted, vector 2 appears next, s_ready returns to 1.
- Strobe mode: EDGE_MODE=1; hold s_valid high for 5 cycles per element, low 3 cycles, 9 times -> exactly 9 captures and one vector; drop_cnt=0.
- Drops: EDGE_MODE=1, m_ready=0, output and assembly full; issue 3 strobes -> drop_cnt=3; stored vectors unchanged.
- Reset mid-operation: after 4 beats, pulse rst 1 cycle with s_valid held high ->
  - m_valid=0, count restarts at lane 0.
  - EDGE_MODE=1: no capture at release until s_valid falls and rises again.
